// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding and sizing constants for the TDC coarse counter
package tdc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} tdc_state_e;
  localparam int TDC_COUNT_WIDTH = 16;
  localparam int TDC_SYNC_MIN = 2;
endpackage

// File: rtl/tdc_edge_sync.sv
// tdc_edge_sync: multi-flop synchronizer with registered rising-edge pulse
module tdc_edge_sync import tdc_pkg::*; #(
  parameter int STAGES = TDC_SYNC_MIN
) (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_pulse,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge i_clk)
    if (!i_nreset) begin
      sync <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], i_pulse};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
    end
endmodule

// File: rtl/tdc_coarse_counter.sv
// tdc_coarse_counter: ring start/stop FSM, saturating edge counter and valid/ready result port
module tdc_coarse_counter import tdc_pkg::*; #(
  parameter int COUNT_WIDTH = TDC_COUNT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_nreset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_pulse,
  output logic                   o_osc_start,
  output logic                   o_osc_nreset,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_overflow,
  output logic                   o_valid,
  input  logic                   i_ready
);
  localparam int STAGES = SYNC_STAGES < TDC_SYNC_MIN ? TDC_SYNC_MIN : SYNC_STAGES;
  localparam int FW = $clog2(STAGES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(STAGES);
  tdc_state_e state;
  logic [FW-1:0] flush_cnt;
  logic rise;
  logic go;
  tdc_edge_sync #(.STAGES(STAGES)) u_sync (
    .i_clk   (i_clk),
    .i_nreset(i_nreset),
    .i_pulse (i_pulse),
    .rise    (rise)
  );
  // a start is honoured from IDLE or as a back-to-back restart on result acceptance
  assign go = i_start & (state == IDLE | (state == DONE & i_ready));
  assign o_osc_start = state == RUN;
  assign o_osc_nreset = state == RUN;
  assign o_busy = state == RUN | state == FLUSH;
  assign o_valid = state == DONE;
  always_ff @(posedge i_clk)
    if (!i_nreset) begin
      state <= IDLE;
      flush_cnt <= '0;
      o_count <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= go ? RUN :
               (state == RUN & i_stop) ? FLUSH :
               (state == FLUSH & flush_cnt == FLUSH_LAST) ? DONE :
               (state == DONE & i_ready) ? IDLE : state;
      flush_cnt <= state == FLUSH ? flush_cnt + 1'b1 : '0;
      if (go) begin
        o_count <= '0;
        o_overflow <= 1'b0;
      end else if (o_busy & rise) begin
        if (&o_count) o_overflow <= 1'b1;
        else o_count <= o_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_tdc_coarse_counter.sv
// tb_tdc_coarse_counter: directed checks on a 16-bit and a 4-bit counter driven in lockstep
module tb_tdc_coarse_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset, start, stop, pulse, ready;
  logic osc_start, osc_nreset, busy, ovf, valid;
  logic [15:0] count;
  logic osc_start4, osc_nreset4, busy4, ovf4, valid4;
  logic [3:0] count4;
  int checks = 0;
  int errors = 0;
  tdc_coarse_counter #(.COUNT_WIDTH(16), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_nreset(nreset), .i_start(start), .i_stop(stop), .i_pulse(pulse),
    .o_osc_start(osc_start), .o_osc_nreset(osc_nreset), .o_busy(busy), .o_count(count),
    .o_overflow(ovf), .o_valid(valid), .i_ready(ready)
  );
  tdc_coarse_counter #(.COUNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .i_clk(clk), .i_nreset(nreset), .i_start(start), .i_stop(stop), .i_pulse(pulse),
    .o_osc_start(osc_start4), .o_osc_nreset(osc_nreset4), .o_busy(busy4), .o_count(count4),
    .o_overflow(ovf4), .o_valid(valid4), .i_ready(ready)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pulse = 1'b1;
      repeat (hi) tick();
      pulse = 1'b0;
      repeat (lo) tick();
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, {28'b0, osc_start, osc_nreset, busy, valid}, 32'h0);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_ovf"}, 32'(ovf), 32'h0);
    chk({tag, "_state4"}, {27'b0, osc_start4, osc_nreset4, busy4, valid4, ovf4}, 32'h0);
    chk({tag, "_count4"}, 32'(count4), 32'h0);
  endtask
  initial begin
    nreset = 1'b0; start = 1'b0; stop = 1'b0; pulse = 1'b0; ready = 1'b0;
    tick(); tick();
    chk_reset("reset");
    nreset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_lat", {28'b0, osc_start, osc_nreset, busy, valid}, 32'he);
    chk("start_count", 32'(count), 32'h0);
    pulses(10, 4, 4);
    chk("run_count", 32'(count), 32'd10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_ring", {29'b0, osc_start, osc_nreset, busy}, 32'h1);
    tick(); tick();
    chk("flush_valid", 32'(valid), 32'h0);
    tick();
    chk("done_valid", 32'(valid), 32'h1);
    chk("basic_count", 32'(count), 32'd10);
    chk("basic_ovf", 32'(ovf), 32'h0);
    chk("basic_count4", 32'(count4), 32'd10);
    for (int i = 0; i < 7; i++) begin
      start = i[0];
      tick();
      chk("hold", {15'b0, valid, busy, count}, {15'b0, 1'b1, 1'b0, 16'd10});
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("accept", {29'b0, valid, busy, osc_nreset}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses(20, 2, 2);
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    chk("ovf_valid", 32'(valid4), 32'h1);
    chk("ovf_count16", 32'(count), 32'd20);
    chk("ovf_flag16", 32'(ovf), 32'h0);
    chk("ovf_count4", 32'(count4), 32'd15);
    chk("ovf_flag4", 32'(ovf4), 32'h1);
    ready = 1'b1;
    start = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    chk("b2b_state", {28'b0, osc_start, osc_nreset, busy, valid}, 32'he);
    chk("b2b_count4", 32'(count4), 32'h0);
    chk("b2b_ovf4", 32'(ovf4), 32'h0);
    pulses(3, 2, 2);
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();
    chk("meas3_count4", 32'(count4), 32'd3);
    chk("meas3_ovf4", 32'(ovf4), 32'h0);
    chk("meas3_valid", 32'(valid), 32'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses(5, 4, 4);
    chk("mid_count", 32'(count), 32'd5);
    nreset = 1'b0;
    tick();
    chk_reset("midreset");
    nreset = 1'b1;
    repeat (6) tick();
    chk("no_result", {30'b0, valid, osc_nreset}, 32'h0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_reset("stop_idle");
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop", {28'b0, osc_start, osc_nreset, busy, valid}, 32'he);
    tick();
    chk("start_stop_run", 32'(osc_nreset), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
